// File: rtl/dut_bus_arbiter.sv
// Round-robin arbiter sharing one registered cmd/adr/data bus between NUM_REQ
// valid/ready requesters, with burst locking of up to MAX_BURST beats per grant.
module dut_bus_arbiter #(
  parameter int           NUM_REQ   = 4,
  parameter int           MAX_BURST = 4,
  parameter logic [3:0]   IDLE_CMD  = 4'h0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [4*NUM_REQ-1:0]       req_cmd,
  input  logic [4*NUM_REQ-1:0]       req_adr,
  input  logic [4*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       bus_stall,
  output logic                       bus_valid,
  output logic [3:0]                 bus_cmd,
  output logic [3:0]                 bus_adr,
  output logic [3:0]                 bus_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  MAX_CNT    = CW'(MAX_BURST);
  localparam logic [IDW-1:0] LAST_RESET = IDW'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic             bus_valid_q, bus_valid_d;
  logic [3:0]       bus_cmd_q, bus_cmd_d;
  logic [3:0]       bus_adr_q, bus_adr_d;
  logic [3:0]       bus_data_q, bus_data_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;

  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;
  logic             accept;
  logic [IDW-1:0]   sel;
  logic [CW-1:0]    cnt_inc;

  // Round-robin scan starting just after the previous winner.
  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign cnt_inc = beat_cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    req_ready    = '0;
    accept       = 1'b0;
    sel          = winner;

    unique case (state_q)
      IDLE: begin
        if (found && !bus_stall) begin
          req_ready[winner] = 1'b1;
          accept            = 1'b1;
          last_grant_d      = winner;
          beat_cnt_d        = CW'(1);
          if (!req_last[winner] && MAX_BURST != 1) begin
            state_d = BURST;
            owner_d = winner;
          end
        end
      end
      BURST: begin
        // The lock holds even while the owner is not offering a beat.
        sel                = owner_q;
        req_ready[owner_q] = ~bus_stall;
        if (req_valid[owner_q] && !bus_stall) begin
          accept     = 1'b1;
          beat_cnt_d = cnt_inc;
          if (req_last[owner_q] || cnt_inc == MAX_CNT) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_valid_d = accept;
    bus_cmd_d   = IDLE_CMD;
    bus_adr_d   = '0;
    bus_data_d  = '0;
    grant_id_d  = grant_id_q;
    if (accept) grant_id_d = sel;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && sel == IDW'(i)) begin
        bus_cmd_d  = req_cmd[4*i +: 4];
        bus_adr_d  = req_adr[4*i +: 4];
        bus_data_d = req_data[4*i +: 4];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      last_grant_q <= LAST_RESET;
      owner_q      <= '0;
      bus_valid_q  <= 1'b0;
      bus_cmd_q    <= IDLE_CMD;
      bus_adr_q    <= '0;
      bus_data_q   <= '0;
      grant_id_q   <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      bus_valid_q  <= bus_valid_d;
      bus_cmd_q    <= bus_cmd_d;
      bus_adr_q    <= bus_adr_d;
      bus_data_q   <= bus_data_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_cmd   = bus_cmd_q;
  assign bus_adr   = bus_adr_q;
  assign bus_data  = bus_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_dut_bus_arbiter.sv
// Directed, table-driven bench for dut_bus_arbiter (NUM_REQ=4, MAX_BURST=4):
// one vector per clock, req_ready checked before the edge, bus outputs after it.
module tb_dut_bus_arbiter;

  localparam int         NUM_REQ   = 4;
  localparam int         MAX_BURST = 4;
  localparam logic [3:0] IDLE_CMD  = 4'h0;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [4*NUM_REQ-1:0] req_cmd;
  logic [4*NUM_REQ-1:0] req_adr;
  logic [4*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 bus_stall;
  logic                 bus_valid;
  logic [3:0]           bus_cmd;
  logic [3:0]           bus_adr;
  logic [3:0]           bus_data;
  logic [1:0]           grant_id;
  logic                 busy;

  dut_bus_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .IDLE_CMD(IDLE_CMD)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last),
    .req_cmd(req_cmd), .req_adr(req_adr), .req_data(req_data),
    .req_ready(req_ready), .bus_stall(bus_stall),
    .bus_valid(bus_valid), .bus_cmd(bus_cmd), .bus_adr(bus_adr), .bus_data(bus_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] last;
    logic       stall;
    logic [3:0] exp_ready;
    logic       exp_bv;
    logic [1:0] exp_gid;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic s, logic [3:0] r,
                              logic bv, logic [1:0] g, logic b);
    vec_t t;
    t.valid = v; t.last = l; t.stall = s; t.exp_ready = r;
    t.exp_bv = bv; t.exp_gid = g; t.exp_busy = b;
    return t;
  endfunction

  // Requester i always offers cmd=i+1, adr=i+8, data=seed+i.
  task automatic apply(input vec_t v, input int seed, input string tag);
    logic [3:0] e_data;
    req_valid = v.valid;
    req_last  = v.last;
    bus_stall = v.stall;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_cmd[4*i +: 4]  = 4'(i + 1);
      req_adr[4*i +: 4]  = 4'(i + 8);
      req_data[4*i +: 4] = 4'(seed + i);
    end
    #1;
    check({tag, " req_ready"}, 32'(req_ready), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    check({tag, " bus_valid"}, 32'(bus_valid), 32'(v.exp_bv));
    if (v.exp_bv) begin
      e_data = 4'(seed + int'(v.exp_gid));
      check({tag, " grant_id"}, 32'(grant_id), 32'(v.exp_gid));
      check({tag, " bus_cmd"},  32'(bus_cmd),  32'(v.exp_gid) + 32'd1);
      check({tag, " bus_adr"},  32'(bus_adr),  32'(v.exp_gid) + 32'd8);
      check({tag, " bus_data"}, 32'(bus_data), 32'(e_data));
    end else begin
      check({tag, " idle bus_cmd"},  32'(bus_cmd),  32'(IDLE_CMD));
      check({tag, " idle bus_adr"},  32'(bus_adr),  32'd0);
      check({tag, " idle bus_data"}, 32'(bus_data), 32'd0);
    end
    check({tag, " busy"}, 32'(busy), 32'(v.exp_busy));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " bus_valid"}, 32'(bus_valid), 32'd0);
    check({tag, " bus_cmd"},   32'(bus_cmd),   32'(IDLE_CMD));
    check({tag, " bus_adr"},   32'(bus_adr),   32'd0);
    check({tag, " bus_data"},  32'(bus_data),  32'd0);
    check({tag, " grant_id"},  32'(grant_id),  32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_cmd   = '0;
    req_adr   = '0;
    req_data  = '0;
    bus_stall = 1'b0;

    // Round robin with single-beat grants.
    vecs.push_back(mk(4'hF, 4'hF, 0, 4'h1, 1, 2'd0, 0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 4'h2, 1, 2'd1, 0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 4'h4, 1, 2'd2, 0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 4'h8, 1, 2'd3, 0));
    vecs.push_back(mk(4'hF, 4'hF, 0, 4'h1, 1, 2'd0, 0));
    // Req 2 six-beat burst, forced release after beat 4.
    vecs.push_back(mk(4'h4, 4'h0, 0, 4'h4, 1, 2'd2, 1));
    vecs.push_back(mk(4'h4, 4'h0, 0, 4'h4, 1, 2'd2, 1));
    vecs.push_back(mk(4'h4, 4'h0, 0, 4'h4, 1, 2'd2, 1));
    vecs.push_back(mk(4'h4, 4'h0, 0, 4'h4, 1, 2'd2, 0));
    vecs.push_back(mk(4'h4, 4'h0, 0, 4'h4, 1, 2'd2, 1));
    vecs.push_back(mk(4'h4, 4'h4, 0, 4'h4, 1, 2'd2, 0));
    // Single beat from req 0 so req 1 is next in line, then req 1 locks while 0/3 wait.
    vecs.push_back(mk(4'h1, 4'h1, 0, 4'h1, 1, 2'd0, 0));
    vecs.push_back(mk(4'hB, 4'h9, 0, 4'h2, 1, 2'd1, 1));
    vecs.push_back(mk(4'hB, 4'h9, 0, 4'h2, 1, 2'd1, 1));
    vecs.push_back(mk(4'hB, 4'hB, 0, 4'h2, 1, 2'd1, 0));
    vecs.push_back(mk(4'h9, 4'h9, 0, 4'h8, 1, 2'd3, 0));
    vecs.push_back(mk(4'h9, 4'h9, 0, 4'h1, 1, 2'd0, 0));
    // Stall for two cycles mid-burst: beat count must not advance.
    vecs.push_back(mk(4'hF, 4'h0, 0, 4'h2, 1, 2'd1, 1));
    vecs.push_back(mk(4'hF, 4'h0, 1, 4'h0, 0, 2'd0, 1));
    vecs.push_back(mk(4'hF, 4'h0, 1, 4'h0, 0, 2'd0, 1));
    vecs.push_back(mk(4'hF, 4'h0, 0, 4'h2, 1, 2'd1, 1));
    vecs.push_back(mk(4'hF, 4'h0, 0, 4'h2, 1, 2'd1, 1));
    vecs.push_back(mk(4'hF, 4'h0, 0, 4'h2, 1, 2'd1, 0));
    // Owner (req 2) drops valid for three cycles; the lock holds.
    vecs.push_back(mk(4'hF, 4'h0, 0, 4'h4, 1, 2'd2, 1));
    vecs.push_back(mk(4'hB, 4'h0, 0, 4'h4, 0, 2'd0, 1));
    vecs.push_back(mk(4'hB, 4'h0, 0, 4'h4, 0, 2'd0, 1));
    vecs.push_back(mk(4'hB, 4'h0, 0, 4'h4, 0, 2'd0, 1));
    vecs.push_back(mk(4'hF, 4'h0, 0, 4'h4, 1, 2'd2, 1));

    #3;
    check_reset_outputs("in reset");
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("after release");

    for (int n = 0; n < vecs.size(); n++)
      apply(vecs[n], n, $sformatf("vec%0d", n));

    // Reset asserted while req 2 is in burst beat 2.
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-burst reset");
    #2;
    rst_n = 1'b1;
    apply(mk(4'hF, 4'hF, 0, 4'h1, 1, 2'd0, 0), 7, "post-reset grant0");
    apply(mk(4'hF, 4'hF, 0, 4'h2, 1, 2'd1, 0), 9, "post-reset grant1");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
